// File: rtl/dcache_wb_if.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_wb_if
//  Description : Bus bundle between the MEM stage, the data cache and the
//                line-wide main data memory.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dcache_wb_if;
   // CPU (MEM stage) side
   logic        cpu_rd;
   logic        cpu_wr;
   logic [15:0] cpu_addr;
   logic [15:0] cpu_wrData;
   logic [15:0] cpu_rdData;
   logic        stall;
   // Memory side
   logic        mem_rd;
   logic        mem_wr;
   logic [13:0] mem_addr;
   logic [63:0] mem_wrLine;
   logic [63:0] mem_rdLine;
   logic        mem_rdy;

   // Cache view
   modport slave (
      input  cpu_rd, cpu_wr, cpu_addr, cpu_wrData, mem_rdLine, mem_rdy,
      output cpu_rdData, stall, mem_rd, mem_wr, mem_addr, mem_wrLine
   );

   // Environment view (pipeline + memory model)
   modport master (
      output cpu_rd, cpu_wr, cpu_addr, cpu_wrData, mem_rdLine, mem_rdy,
      input  cpu_rdData, stall, mem_rd, mem_wr, mem_addr, mem_wrLine
   );
endinterface
`default_nettype wire

// File: rtl/dcache_wb.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_wb
//  Description : Direct-mapped, write-back, write-allocate data cache with
//                4 x 16-bit words per line. Hits are serviced with zero
//                latency; misses stall the pipeline while a dirty victim is
//                written back and the requested line is filled.
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_wb #(
   parameter int INDEX_BITS = 3
) (
   input  wire logic    clk,
   input  wire logic    rst_n,
   dcache_wb_if.slave   bus_if
);

   localparam int C_LINES    = 1 << INDEX_BITS;
   localparam int C_TAG_BITS = 14 - INDEX_BITS;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WRBACK = 2'd1,
      S_FILL   = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [C_LINES-1:0]     valid_q, valid_d;
   logic [C_LINES-1:0]     dirty_q, dirty_d;
   // Line address of the miss being serviced; keeps the transfer coherent
   // even if the requester drops or changes its address while stalled.
   logic [13:0]            miss_addr_q, miss_addr_d;

   // Tag and data arrays carry no reset: valid bits gate every use.
   logic [C_TAG_BITS-1:0]  tag_q  [C_LINES];
   logic [63:0]            line_q [C_LINES];

   logic                   w_req;
   logic [1:0]             w_off;
   logic [5:0]             w_bitpos;
   logic [INDEX_BITS-1:0]  w_idx;
   logic [C_TAG_BITS-1:0]  w_tag;
   logic                   w_hit;
   logic [15:0]            w_word;
   logic [INDEX_BITS-1:0]  w_xidx;
   logic [C_TAG_BITS-1:0]  w_xtag;
   logic                   w_fill_en;
   logic                   w_store_en;

   logic [15:0]            w_rdData;
   logic                   w_stall;
   logic                   w_mem_rd;
   logic                   w_mem_wr;
   logic [13:0]            w_mem_addr;
   logic [63:0]            w_mem_wrLine;

   // Address decode and hit detection for the current request
   assign w_req    = bus_if.cpu_rd | bus_if.cpu_wr;
   assign w_off    = bus_if.cpu_addr[1:0];
   assign w_bitpos = {w_off, 4'b0000};
   assign w_idx    = bus_if.cpu_addr[INDEX_BITS+1:2];
   assign w_tag    = bus_if.cpu_addr[15:INDEX_BITS+2];
   assign w_hit    = valid_q[w_idx] && (tag_q[w_idx] == w_tag);
   assign w_word   = line_q[w_idx][w_bitpos +: 16];

   // Index/tag of the line under transfer
   assign w_xidx   = miss_addr_q[INDEX_BITS-1:0];
   assign w_xtag   = miss_addr_q[13:INDEX_BITS];

   // Next-state, status bits and bus outputs
   always_comb begin
      state_d      = state_q;
      valid_d      = valid_q;
      dirty_d      = dirty_q;
      miss_addr_d  = miss_addr_q;
      w_rdData     = 16'h0000;
      w_stall      = 1'b0;
      w_mem_rd     = 1'b0;
      w_mem_wr     = 1'b0;
      w_mem_addr   = 14'h0000;
      w_mem_wrLine = 64'h0;
      w_fill_en    = 1'b0;
      w_store_en   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (w_req) begin
               if (w_hit) begin
                  // Loads and stores both expose the pre-write word
                  w_rdData = w_word;
                  if (bus_if.cpu_wr) begin
                     w_store_en     = 1'b1;
                     dirty_d[w_idx] = 1'b1;
                  end
               end else begin
                  w_stall     = 1'b1;
                  miss_addr_d = bus_if.cpu_addr[15:2];
                  if (valid_q[w_idx] && dirty_q[w_idx]) begin
                     state_d = S_WRBACK;
                  end else begin
                     state_d = S_FILL;
                  end
               end
            end
         end

         S_WRBACK: begin
            w_stall      = 1'b1;
            w_mem_wr     = 1'b1;
            w_mem_addr   = {tag_q[w_xidx], w_xidx};
            w_mem_wrLine = line_q[w_xidx];
            if (bus_if.mem_rdy) begin
               dirty_d[w_xidx] = 1'b0;
               state_d         = S_FILL;
            end
         end

         S_FILL: begin
            w_stall    = 1'b1;
            w_mem_rd   = 1'b1;
            w_mem_addr = miss_addr_q;
            if (bus_if.mem_rdy) begin
               w_fill_en       = 1'b1;
               valid_d[w_xidx] = 1'b1;
               dirty_d[w_xidx] = 1'b0;
               state_d         = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, status bits and miss address; reset aborts any transfer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         valid_q     <= '0;
         dirty_q     <= '0;
         miss_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         dirty_q     <= dirty_d;
         miss_addr_q <= miss_addr_d;
      end
   end

   // Tag/data array writes: line install on fill, word merge on store hit
   always_ff @(posedge clk) begin
      if (w_fill_en) begin
         line_q[w_xidx] <= bus_if.mem_rdLine;
         tag_q[w_xidx]  <= w_xtag;
      end else if (w_store_en) begin
         line_q[w_idx][w_bitpos +: 16] <= bus_if.cpu_wrData;
      end
   end

   assign bus_if.cpu_rdData = w_rdData;
   assign bus_if.stall      = w_stall;
   assign bus_if.mem_rd     = w_mem_rd;
   assign bus_if.mem_wr     = w_mem_wr;
   assign bus_if.mem_addr   = w_mem_addr;
   assign bus_if.mem_wrLine = w_mem_wrLine;

endmodule
`default_nettype wire

// File: tb/tb_dcache_wb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dcache_wb
//  Description : Self-checking bench for dcache_wb. A transaction-level
//                cache model is compared against the DUT every cycle, and
//                directed scenarios pin literal expected values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_wb;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   dcache_wb_if bus_if ();

   dcache_wb #(.INDEX_BITS(3)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_if (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------------
   // Comparison helper
   // ---------------------------------------------------------------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------
   // Behavioural model: cache contents as words plus a queue of memory
   // transfers the cache still owes (write-back first, then fill).
   // ---------------------------------------------------------------------
   typedef struct {
      bit          is_rd;
      logic [13:0] addr;
      logic [63:0] line;
   } xfer_t;

   bit          mv [8];
   bit          md [8];
   logic [10:0] mt [8];
   logic [15:0] mw [8][4];
   xfer_t       xq [$];

   function automatic logic [63:0] model_line(input int i);
      return {mw[i][3], mw[i][2], mw[i][1], mw[i][0]};
   endfunction

   // Compare every cycle on the falling edge, then advance the model by the
   // effect of the coming rising edge (inputs are stable until then).
   always @(negedge clk) begin : model_cmp
      bit          req;
      bit          hit;
      int          idx;
      int          off;
      int          xi;
      logic [10:0] tg;
      xfer_t       x;

      if (!rst_n) begin
         for (int i = 0; i < 8; i++) begin
            mv[i] = 1'b0;
            md[i] = 1'b0;
         end
         xq.delete();
      end

      req = bus_if.cpu_rd | bus_if.cpu_wr;
      idx = int'(bus_if.cpu_addr[4:2]);
      off = int'(bus_if.cpu_addr[1:0]);
      tg  = bus_if.cpu_addr[15:5];
      hit = mv[idx] && (mt[idx] == tg);

      if (xq.size() != 0) begin
         check("m_stall",   64'(bus_if.stall),      64'd1);
         check("m_rdData",  64'(bus_if.cpu_rdData), 64'd0);
         check("m_mem_rd",  64'(bus_if.mem_rd),     64'(xq[0].is_rd));
         check("m_mem_wr",  64'(bus_if.mem_wr),     64'(!xq[0].is_rd));
         check("m_mem_addr",64'(bus_if.mem_addr),   64'(xq[0].addr));
         check("m_wrLine",  bus_if.mem_wrLine,      xq[0].is_rd ? 64'd0 : xq[0].line);
      end else begin
         check("m_stall",   64'(bus_if.stall),      64'(req && !hit));
         check("m_rdData",  64'(bus_if.cpu_rdData), (req && hit) ? 64'(mw[idx][off]) : 64'd0);
         check("m_mem_rd",  64'(bus_if.mem_rd),     64'd0);
         check("m_mem_wr",  64'(bus_if.mem_wr),     64'd0);
         check("m_mem_addr",64'(bus_if.mem_addr),   64'd0);
         check("m_wrLine",  bus_if.mem_wrLine,      64'd0);
      end

      if (rst_n) begin
         if (xq.size() != 0) begin
            if (bus_if.mem_rdy) begin
               xi = int'(xq[0].addr[2:0]);
               if (xq[0].is_rd) begin
                  mv[xi] = 1'b1;
                  md[xi] = 1'b0;
                  mt[xi] = xq[0].addr[13:3];
                  for (int w = 0; w < 4; w++) mw[xi][w] = bus_if.mem_rdLine[16*w +: 16];
               end else begin
                  md[xi] = 1'b0;
               end
               void'(xq.pop_front());
            end
         end else if (req) begin
            if (hit) begin
               if (bus_if.cpu_wr) begin
                  mw[idx][off] = bus_if.cpu_wrData;
                  md[idx]      = 1'b1;
               end
            end else begin
               if (mv[idx] && md[idx]) begin
                  x.is_rd = 1'b0;
                  x.addr  = {mt[idx], 3'(idx)};
                  x.line  = model_line(idx);
                  xq.push_back(x);
               end
               x.is_rd = 1'b1;
               x.addr  = bus_if.cpu_addr[15:2];
               x.line  = 64'd0;
               xq.push_back(x);
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d);
      bus_if.cpu_rd     = rd;
      bus_if.cpu_wr     = wr;
      bus_if.cpu_addr   = a;
      bus_if.cpu_wrData = d;
   endtask

   task automatic rdy(input bit v, input logic [63:0] line);
      bus_if.mem_rdy    = v;
      bus_if.mem_rdLine = line;
   endtask

   // ---------------------------------------------------------------------
   // Directed scenarios
   // ---------------------------------------------------------------------
   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      drive(0, 0, 16'h0000, 16'h0000);
      rdy(0, 64'd0);

      tick(); tick(); #1;
      check("rst_stall",  64'(bus_if.stall),      64'd0);
      check("rst_rdData", 64'(bus_if.cpu_rdData), 64'd0);
      check("rst_mem_rd", 64'(bus_if.mem_rd),     64'd0);
      check("rst_mem_wr", 64'(bus_if.mem_wr),     64'd0);
      rst_n = 1'b1;
      tick();

      // 1: clean miss after reset
      drive(1, 0, 16'h0041, 16'h0000); #1;
      check("s1_stall0",  64'(bus_if.stall),  64'd1);
      check("s1_nomemrd", 64'(bus_if.mem_rd), 64'd0);
      tick(); #1;
      check("s1_mem_rd",  64'(bus_if.mem_rd),   64'd1);
      check("s1_addr",    64'(bus_if.mem_addr), 64'h0010);
      check("s1_mem_wr",  64'(bus_if.mem_wr),   64'd0);
      tick(); tick();
      rdy(1, 64'h4444_3333_2222_1111);
      tick();
      rdy(0, 64'd0); #1;
      check("s1_stall",   64'(bus_if.stall),      64'd0);
      check("s1_rdData",  64'(bus_if.cpu_rdData), 64'h2222);

      // 2: store hit, then loads
      tick();
      drive(0, 1, 16'h0042, 16'hBEEF); #1;
      check("s2_stall",   64'(bus_if.stall),  64'd0);
      check("s2_mem_rd",  64'(bus_if.mem_rd), 64'd0);
      check("s2_mem_wr",  64'(bus_if.mem_wr), 64'd0);
      tick();
      drive(1, 0, 16'h0042, 16'h0000); #1;
      check("s2_ld42",    64'(bus_if.cpu_rdData), 64'hBEEF);
      tick();
      drive(1, 0, 16'h0043, 16'h0000); #1;
      check("s2_ld43",    64'(bus_if.cpu_rdData), 64'h4444);

      // 3: dirty miss on the same index
      tick();
      drive(1, 0, 16'h0022, 16'h0000); #1;
      check("s3_stall0",  64'(bus_if.stall), 64'd1);
      tick(); #1;
      check("s3_mem_wr",  64'(bus_if.mem_wr),     64'd1);
      check("s3_mem_rd",  64'(bus_if.mem_rd),     64'd0);
      check("s3_wbaddr",  64'(bus_if.mem_addr),   64'h0010);
      check("s3_wbline",  bus_if.mem_wrLine,      64'h4444_BEEF_2222_1111);
      tick();
      rdy(1, 64'd0);
      tick();
      rdy(0, 64'd0); #1;
      check("s3_fill_rd", 64'(bus_if.mem_rd),   64'd1);
      check("s3_fill_wr", 64'(bus_if.mem_wr),   64'd0);
      check("s3_fill_ad", 64'(bus_if.mem_addr), 64'h0008);
      tick();
      rdy(1, 64'h0000_CCCC_0000_0000);
      tick();
      rdy(0, 64'd0); #1;
      check("s3_stall",   64'(bus_if.stall),      64'd0);
      check("s3_rdData",  64'(bus_if.cpu_rdData), 64'hCCCC);

      // 4: clean victim, fill only
      tick();
      drive(1, 0, 16'h0040, 16'h0000); #1;
      check("s4_stall0",  64'(bus_if.stall), 64'd1);
      tick(); #1;
      check("s4_mem_wr",  64'(bus_if.mem_wr),   64'd0);
      check("s4_mem_rd",  64'(bus_if.mem_rd),   64'd1);
      check("s4_addr",    64'(bus_if.mem_addr), 64'h0010);
      tick();
      rdy(1, 64'h4444_BEEF_2222_1111);
      tick();
      rdy(0, 64'd0); #1;
      check("s4_rdData",  64'(bus_if.cpu_rdData), 64'h1111);

      // 5: store miss allocates and merges, then eviction writes it back
      tick();
      drive(0, 1, 16'h0007, 16'h1234); #1;
      check("s5_stall0",  64'(bus_if.stall), 64'd1);
      tick(); #1;
      check("s5_mem_rd",  64'(bus_if.mem_rd),   64'd1);
      check("s5_addr",    64'(bus_if.mem_addr), 64'h0001);
      tick();
      rdy(1, 64'hAAAA_BBBB_CCCC_DDDD);
      tick();
      rdy(0, 64'd0); #1;
      check("s5_stall",   64'(bus_if.stall), 64'd0);
      tick();
      drive(1, 0, 16'h0007, 16'h0000); #1;
      check("s5_ld07",    64'(bus_if.cpu_rdData), 64'h1234);
      tick();
      drive(1, 0, 16'h0027, 16'h0000); #1;
      check("s5_stall1",  64'(bus_if.stall), 64'd1);
      tick(); #1;
      check("s5_mem_wr",  64'(bus_if.mem_wr),   64'd1);
      check("s5_wbaddr",  64'(bus_if.mem_addr), 64'h0001);
      check("s5_wbline",  bus_if.mem_wrLine,    64'h1234_BBBB_CCCC_DDDD);
      tick();
      rdy(1, 64'd0);
      tick();
      rdy(0, 64'd0); #1;
      check("s5_fill_ad", 64'(bus_if.mem_addr), 64'h0009);
      tick();
      rdy(1, 64'h5555_6666_7777_8888);
      tick();
      rdy(0, 64'd0); #1;
      check("s5_rdData",  64'(bus_if.cpu_rdData), 64'h5555);

      // 6: reset in the middle of a fill
      tick();
      drive(1, 0, 16'h0088, 16'h0000); #1;
      check("s6_stall0",  64'(bus_if.stall), 64'd1);
      tick(); #1;
      check("s6_mem_rd",  64'(bus_if.mem_rd),   64'd1);
      check("s6_addr",    64'(bus_if.mem_addr), 64'h0022);
      tick();
      rst_n = 1'b0; #1;
      check("s6_rst_rd",  64'(bus_if.mem_rd),   64'd0);
      check("s6_rst_ad",  64'(bus_if.mem_addr), 64'd0);
      check("s6_rst_st",  64'(bus_if.stall),    64'd1);
      tick();
      drive(0, 0, 16'h0000, 16'h0000); #1;
      check("s6_idle_st", 64'(bus_if.stall), 64'd0);
      rst_n = 1'b1;
      tick();
      drive(1, 0, 16'h0040, 16'h0000); #1;
      check("s6_remiss",  64'(bus_if.stall), 64'd1);
      tick(); #1;
      check("s6_reissue", 64'(bus_if.mem_rd),   64'd1);
      check("s6_re_addr", 64'(bus_if.mem_addr), 64'h0010);
      check("s6_re_wr",   64'(bus_if.mem_wr),   64'd0);
      tick();
      rdy(1, 64'h0101_0202_0303_0404);
      tick();
      rdy(0, 64'd0); #1;
      check("s6_rdData",  64'(bus_if.cpu_rdData), 64'h0404);
      tick();
      drive(0, 0, 16'h0000, 16'h0000);
      tick(); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
